ov5640_frame_crop: RTL and testbench
====================================

OV5640_FRAME_CROP -- requirements
Module: ov5640_frame_crop

Interface
REQ-001 Parameter X_START, default 0, first captured pixel column (0-based).
REQ-002 Parameter Y_START, default 0, first captured line (0-based).
REQ-003 Parameter WIN_W, default 1280, window width in pixels (1..4095).
REQ-004 Parameter WIN_H, default 720, window height in lines (1..4095).
REQ-005 cam_pclk  in  1  sole clock; every register updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_ce  in  1  pixel clock enable from the capture stage.
REQ-008 in_vsync  in  1  frame sync; a 1->0 transition marks frame start.
REQ-009 in_href  in  1  line active; a 1->0 transition marks line end.
REQ-010 in_de  in  1  pixel valid; honoured only when in_ce=1.
REQ-011 in_data  in  24  RGB888 pixel.
REQ-012 fifo_full  in  1  downstream write FIFO full.
REQ-013 wr_en  out  1  FIFO write strobe.
REQ-014 wr_data  out  26  {sof, eol, pixel[23:0]}.
REQ-015 frame_done  out  1  one-cycle pulse when the last window pixel is written.
REQ-016 short_frame  out  1  one-cycle pulse when a frame ends before the window completes.
REQ-017 overflow  out  1  sticky; set when a frame is dropped, cleared at next frame start.
REQ-018 drop_cnt  out  8  count of dropped frames, saturating at 255.

Function
REQ-019 The block SHALL register in_vsync and in_href every cycle and detect their 1->0 edges from the registered copy versus the current input.
REQ-020 A pixel event SHALL be in_ce & in_de & in_href.
REQ-021 Column counter x (12 b) SHALL increment on each pixel event and clear on the href falling edge.
REQ-022 Line counter y (12 b) SHALL increment on an href falling edge only if x>0, and clear on frame start.
REQ-023 The FSM SHALL have states IDLE, ACTIVE, DROP; after reset it is IDLE.
REQ-024 IDLE->ACTIVE on frame start; pixels arriving in IDLE are ignored.
REQ-025 In ACTIVE, a pixel event with X_START<=x<X_START+WIN_W and Y_START<=y<Y_START+WIN_H SHALL write that pixel.
REQ-026 The write SHALL appear one cycle after the pixel event: wr_en=1, wr_data[23:0]=in_data.
REQ-027 sof=1 only on the window's first pixel (x=X_START, y=Y_START); eol=1 only when x=X_START+WIN_W-1.
REQ-028 When the window's last pixel is written, frame_done SHALL pulse in the same cycle as its wr_en, and the FSM SHALL go to IDLE.
REQ-029 An in-window pixel event while fifo_full=1 SHALL produce no write. Set overflow, increment drop_cnt (saturating), go to DROP.
REQ-030 DROP SHALL suppress all writes until the next frame start, which enters ACTIVE.
REQ-031 Frame start while in ACTIVE SHALL pulse short_frame, reset x and y, and stay ACTIVE; the truncated frame is not counted in drop_cnt.
REQ-032 On frame start in any state, overflow SHALL clear. If a dropped-frame event coincides with frame start, the frame-start action wins.
REQ-033 fifo_full SHALL be ignored when no in-window pixel event occurs.
REQ-034 Lines beyond Y_START+WIN_H-1 and columns beyond X_START+WIN_W-1 SHALL be discarded silently; counters saturate at 4095.

Reset
REQ-035 While rst=1 at a clock edge, all of the following SHALL be 0 on the next cycle: state=IDLE, x, y, edge registers, wr_en, wr_data, frame_done, short_frame, overflow, drop_cnt.
REQ-036 Reset asserted mid-frame SHALL abandon the frame. After release, the block waits in IDLE for the next frame start.

Verification
REQ-037 Reset the block with WIN_W=4, WIN_H=2, X_START=1, Y_START=1. Drive three 6-pixel lines. Expect 8 writes: sof on (1,1), eol at x=4 on both window lines, frame_done on the 8th write.
REQ-038 Use the same frame with fifo_full=1 during the 3rd window pixel. Expect 2 writes, overflow=1, drop_cnt=1, and no frame_done. The next frame gives 8 writes and clears overflow.
REQ-039 Start a new frame after only one window line. Expect a short_frame pulse, no frame_done, and the following frame captured normally.
REQ-040 Toggle in_ce=0 on alternate cycles with in_de=1. Expect only the ce=1 cycles counted, and the write count unchanged versus the full-rate case.
REQ-041 Assert rst for one cycle mid-line. Expect all outputs 0 next cycle and no writes until the next vsync falling edge.
REQ-042 Force 256 consecutive overflow frames. Expect drop_cnt to hold at 255.

Source files
------------

// File: rtl/ov5640_frame_crop.sv
// rtl/ov5640_frame_crop.sv - crops a fixed window out of a camera pixel stream into a write FIFO
module ov5640_frame_crop #(
    parameter int X_START = 0,
    parameter int Y_START = 0,
    parameter int WIN_W   = 1280,
    parameter int WIN_H   = 720
) (
    input  logic        cam_pclk,
    input  logic        rst,
    input  logic        in_ce,
    input  logic        in_vsync,
    input  logic        in_href,
    input  logic        in_de,
    input  logic [23:0] in_data,
    input  logic        fifo_full,
    output logic        wr_en,
    output logic [25:0] wr_data,
    output logic        frame_done,
    output logic        short_frame,
    output logic        overflow,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } state_t;

    // Window bounds held at 13 bits so X_START+WIN_W never wraps the compare.
    localparam logic [12:0] X_LO   = 13'(X_START);
    localparam logic [12:0] Y_LO   = 13'(Y_START);
    localparam logic [12:0] W13    = 13'(WIN_W);
    localparam logic [12:0] H13    = 13'(WIN_H);
    localparam logic [12:0] X_LAST = 13'(X_START + WIN_W - 1);
    localparam logic [12:0] Y_LAST = 13'(Y_START + WIN_H - 1);
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    state_t      state_q, state_d;
    logic        vsync_q, href_q;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic        wr_en_q, wr_en_d;
    logic [25:0] wr_data_q, wr_data_d;
    logic        frame_done_q, frame_done_d;
    logic        short_q, short_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  drop_q, drop_d;

    logic        frame_start, line_end, pix_ev;
    logic [12:0] x_ext, y_ext;
    logic        in_win, is_sof, is_eol, is_last;

    // Edge detection, window position decode and all next-state decisions.
    always_comb begin
        frame_start = vsync_q & ~in_vsync;
        line_end    = href_q & ~in_href;
        pix_ev      = in_ce & in_de & in_href;
        x_ext       = {1'b0, x_q};
        y_ext       = {1'b0, y_q};
        // Unsigned subtraction wraps far above any legal width when below the start.
        in_win      = ((x_ext - X_LO) < W13) && ((y_ext - Y_LO) < H13);
        is_sof      = (x_ext == X_LO) && (y_ext == Y_LO);
        is_eol      = (x_ext == X_LAST);
        is_last     = is_eol && (y_ext == Y_LAST);

        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        short_d      = 1'b0;
        ovf_d        = ovf_q;
        drop_d       = drop_q;

        if (frame_start) begin
            x_d = 12'd0;
            y_d = 12'd0;
        end else if (line_end) begin
            x_d = 12'd0;
            if (x_q != 12'd0 && y_q != CNT_MAX) begin
                y_d = y_q + 12'd1;
            end
        end else if (pix_ev && x_q != CNT_MAX) begin
            x_d = x_q + 12'd1;
        end

        // Frame start overrides any pixel decision in the same cycle.
        if (frame_start) begin
            ovf_d   = 1'b0;
            state_d = ACTIVE;
            if (state_q == ACTIVE) begin
                short_d = 1'b1;
            end
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (pix_ev && in_win) begin
                        if (fifo_full) begin
                            ovf_d   = 1'b1;
                            state_d = DROP;
                            if (drop_q != 8'hFF) begin
                                drop_d = drop_q + 8'd1;
                            end
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = {is_sof, is_eol, in_data};
                            if (is_last) begin
                                frame_done_d = 1'b1;
                                state_d      = IDLE;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, counters, edge history and registered outputs.
    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            x_q          <= 12'd0;
            y_q          <= 12'd0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 26'd0;
            frame_done_q <= 1'b0;
            short_q      <= 1'b0;
            ovf_q        <= 1'b0;
            drop_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= in_vsync;
            href_q       <= in_href;
            x_q          <= x_d;
            y_q          <= y_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            short_q      <= short_d;
            ovf_q        <= ovf_d;
            drop_q       <= drop_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign short_frame = short_q;
    assign overflow    = ovf_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_ov5640_frame_crop.sv
// tb/tb_ov5640_frame_crop.sv - self-checking bench for ov5640_frame_crop
module tb_ov5640_frame_crop;

    localparam int XS = 1;
    localparam int YS = 1;
    localparam int W  = 4;
    localparam int H  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_ce = 1'b0, in_vsync = 1'b0, in_href = 1'b0, in_de = 1'b0;
    logic [23:0] in_data = 24'd0;
    logic        fifo_full = 1'b0;
    logic        wr_en, frame_done, short_frame, overflow;
    logic [25:0] wr_data;
    logic [7:0]  drop_cnt;

    ov5640_frame_crop #(.X_START(XS), .Y_START(YS), .WIN_W(W), .WIN_H(H)) dut (
        .cam_pclk(clk), .rst(rst), .in_ce(in_ce), .in_vsync(in_vsync), .in_href(in_href),
        .in_de(in_de), .in_data(in_data), .fifo_full(fifo_full), .wr_en(wr_en),
        .wr_data(wr_data), .frame_done(frame_done), .short_frame(short_frame),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed traffic, sampled on the falling edge.
    logic [26:0] obs_q[$];
    int obs_fd = 0;
    int obs_short = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) obs_q.push_back({frame_done, wr_data});
            if (frame_done) obs_fd <= obs_fd + 1;
            if (short_frame) obs_short <= obs_short + 1;
        end
    end

    // Reference model: which window pixels of the current frame should land in the FIFO.
    logic [26:0] exp_q[$];
    bit m_active = 0;
    int m_widx = 0;
    int exp_fd = 0, exp_short = 0, exp_ovf = 0, exp_drop = 0;
    int cur_line = 0, cur_col = 0, f_winev = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        in_ce = 1'b0;
        in_de = 1'b0;
        in_href = 1'b0;
        fifo_full = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".wr_en"}, 32'(wr_en), 0);
        check_eq({tag, ".wr_data"}, 32'(wr_data), 0);
        check_eq({tag, ".frame_done"}, 32'(frame_done), 0);
        check_eq({tag, ".short"}, 32'(short_frame), 0);
        check_eq({tag, ".overflow"}, 32'(overflow), 0);
        check_eq({tag, ".drop_cnt"}, 32'(drop_cnt), 0);
    endtask

    task automatic model_reset();
        m_active = 0;
        exp_ovf = 0;
        exp_drop = 0;
    endtask

    task automatic frame_start();
        quiet();
        in_vsync = 1'b1;
        tick();
        tick();
        in_vsync = 1'b0;
        tick();
        if (m_active && m_widx < W * H) exp_short++;
        m_active = 1;
        m_widx = 0;
        exp_ovf = 0;
        cur_line = 0;
        cur_col = 0;
        f_winev = 0;
    endtask

    // ce_mode 0: full rate, 1: ce alternates, 2: random ce and de.
    // full_win: in-window pixel index that sees fifo_full (-1 none).
    // rst_after: pulse reset after this many pixel events of the line (-1 none).
    task automatic drive_line(input int npix, input int ce_mode, input int full_win,
                              input int full_pct, input int rst_after);
        int ev;
        bit ce_t;
        bit inwin, sof, eol, last;
        ev = 0;
        ce_t = 1;
        while (ev < npix) begin
            in_href = 1'b1;
            in_ce = (ce_mode == 0) ? 1'b1 : (ce_mode == 1) ? ce_t : 1'($urandom_range(0, 1));
            in_de = (ce_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            ce_t = ~ce_t;
            in_data = 24'($urandom);
            fifo_full = ($urandom_range(0, 99) < full_pct) || (ce_mode != 0 && $urandom_range(0, 1) == 1 && !(in_ce && in_de));
            if (in_ce && in_de) begin
                inwin = cur_col >= XS && cur_col < XS + W && cur_line >= YS && cur_line < YS + H;
                if (inwin && f_winev == full_win) fifo_full = 1'b1;
                if (inwin) f_winev++;
                if (m_active && inwin) begin
                    if (fifo_full) begin
                        m_active = 0;
                        exp_ovf = 1;
                        if (exp_drop < 255) exp_drop++;
                    end else begin
                        sof = (cur_col == XS) && (cur_line == YS);
                        eol = (cur_col == XS + W - 1);
                        last = eol && (cur_line == YS + H - 1);
                        exp_q.push_back({last, sof, eol, in_data});
                        m_widx++;
                        if (last) begin
                            exp_fd++;
                            m_active = 0;
                        end
                    end
                end
                cur_col++;
                ev++;
            end
            tick();
            if (ev == rst_after) begin
                in_ce = 1'b0;
                in_de = 1'b0;
                tick();
                rst = 1'b1;
                tick();
                check_reset_outputs("midline_rst");
                rst = 1'b0;
                model_reset();
                rst_after = -1;
            end
        end
        quiet();
        tick();
        tick();
        if (npix > 0) cur_line++;
        cur_col = 0;
    endtask

    task automatic end_frame(input string tag, input int want_n);
        int n;
        logic [26:0] o, e;
        quiet();
        in_vsync = 1'b1;
        tick();
        tick();
        tick();
        if (want_n >= 0) check_eq({tag, ".nwr_const"}, obs_q.size(), want_n);
        check_eq({tag, ".nwr"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check_eq($sformatf("%s.wr%0d", tag, i), 32'(o), 32'(e));
        end
        obs_q.delete();
        exp_q.delete();
        check_eq({tag, ".frame_done_cnt"}, obs_fd, exp_fd);
        check_eq({tag, ".short_cnt"}, obs_short, exp_short);
        check_eq({tag, ".overflow"}, 32'(overflow), exp_ovf);
        check_eq({tag, ".drop_cnt"}, 32'(drop_cnt), exp_drop);
    endtask

    task automatic full_frame(input string tag, input int nl, input int np, input int ce_mode,
                              input int full_win, input int want_n);
        frame_start();
        for (int l = 0; l < nl; l++) drive_line(np, ce_mode, full_win, 0, -1);
        end_frame(tag, want_n);
    endtask

    initial begin
        quiet();
        fifo_full = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic 3x6 frame, then one with a full FIFO on the third window pixel.
        full_frame("basic", 3, 6, 0, -1, 8);
        full_frame("ovf", 3, 6, 0, 2, 2);
        full_frame("after_ovf", 3, 6, 0, -1, 8);

        // Frame cut short after one window line, then a normal frame.
        frame_start();
        drive_line(6, 0, -1, 0, -1);
        drive_line(6, 0, -1, 0, -1);
        end_frame("short", 4);
        full_frame("after_short", 3, 6, 0, -1, 8);

        // Half-rate clock enable must not change the result.
        full_frame("half_ce", 3, 6, 1, -1, 8);

        // Reset pulse in the middle of the first window line.
        frame_start();
        drive_line(6, 0, -1, 0, -1);
        drive_line(6, 0, -1, 0, 3);
        drive_line(6, 0, -1, 0, -1);
        end_frame("midrst", 2);
        full_frame("after_rst", 3, 6, 0, -1, 8);

        // Randomised frames.
        for (int f = 0; f < 40; f++) begin
            frame_start();
            for (int l = $urandom_range(0, 4); l > 0; l--)
                drive_line($urandom_range(0, 7), $urandom_range(0, 2),
                           ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1,
                           ($urandom_range(0, 3) == 0) ? 10 : 0, -1);
            end_frame($sformatf("rand%0d", f), -1);
        end

        // Enough dropped frames to saturate the counter.
        for (int f = 0; f < 258; f++) begin
            frame_start();
            drive_line(2, 0, 0, 0, -1);
            drive_line(2, 0, 0, 0, -1);
            end_frame("sat", 0);
        end
        check_eq("sat.drop_cnt_255", 32'(drop_cnt), 255);
        full_frame("after_sat", 3, 6, 0, -1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
